// File: rtl/snn_pkg.sv
// snn_pkg: shared scheduler state encoding, LIF arithmetic helpers and default datapath sizes.
package snn_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_THRESH = 32;
  typedef enum logic [2:0] {S_IDLE, S_RD, S_CALC, S_SPK, S_CLR, S_DONE} sched_state_t;
  // Operands arrive sign-extended to 64 bits, so the exact sum leaves bit w equal to bit w-1 unless w bits overflow.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a, input logic signed [63:0] b,
                                                 input int w, input logic signed [63:0] th);
    logic signed [63:0] s;
    s = a + b;
    return (s[w] != s[w-1]) ? ((a < 0) ? -th : th) : s;
  endfunction
  function automatic logic at_thresh(input logic signed [63:0] s, input logic signed [63:0] th);
    return s >= th;
  endfunction
endpackage

// File: rtl/lif_update.sv
// lif_update: combinational saturating integrate, threshold and optional halving leak for one neuron.
module lif_update
  import snn_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int THRESH = DEF_THRESH,
  parameter int RESET_VAL = 0
) (
  input  logic signed [WIDTH-1:0] mem,
  input  logic signed [WIDTH-1:0] cur,
  input  logic                    leak,
  output logic signed [WIDTH-1:0] next_mem,
  output logic                    fire
);
  logic signed [63:0] w_sum_c;
  logic signed [WIDTH-1:0] w_sum;
  always_comb begin
    w_sum_c = sat_add(64'(mem), 64'(cur), WIDTH, 64'(THRESH));
    w_sum = w_sum_c[WIDTH-1:0];
    fire = at_thresh(w_sum_c, 64'(THRESH));
    next_mem = fire ? WIDTH'(RESET_VAL) : leak ? w_sum >>> 1 : w_sum;
  end
endmodule

// File: rtl/lif_layer_sched.sv
// lif_layer_sched: walks every neuron of a layer once per start, updating membranes and streaming spike indices.
module lif_layer_sched
  import snn_pkg::*;
#(
  parameter int N_NEURONS = 256,
  parameter int WIDTH = DEF_WIDTH,
  parameter int THRESH = DEF_THRESH,
  parameter int RESET_VAL = 0,
  parameter int ADDR_W = $clog2(N_NEURONS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clear,
  input  logic              leak,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  mem_rd_data,
  input  logic [WIDTH-1:0]  cur_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [WIDTH-1:0]  mem_wr_data,
  output logic              spk_valid,
  output logic [ADDR_W-1:0] spk_idx,
  input  logic              spk_ready
);
  sched_state_t r_state, w_state_n;
  logic [ADDR_W:0] r_idx, w_idx_n;
  logic r_leak;
  logic r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [WIDTH-1:0] r_wr_data;
  logic r_spk_valid;
  logic [ADDR_W-1:0] r_spk_idx;
  logic signed [WIDTH-1:0] w_next_mem;
  logic w_fire, w_last, w_adv, w_wr;

  lif_update #(.WIDTH(WIDTH), .THRESH(THRESH), .RESET_VAL(RESET_VAL)) u_update (
    .mem(mem_rd_data),
    .cur(cur_rd_data),
    .leak(r_leak),
    .next_mem(w_next_mem),
    .fire(w_fire)
  );

  assign w_last = r_idx == (ADDR_W+1)'(N_NEURONS - 1);
  assign w_adv = (r_state == S_CALC && !w_fire) || (r_state == S_SPK && spk_ready) || r_state == S_CLR;
  assign w_wr = r_state == S_CALC || r_state == S_CLR;

  always_comb begin
    w_state_n = r_state;
    w_idx_n = r_idx;
    if (r_state == S_IDLE && start) begin
      w_state_n = clear ? S_CLR : S_RD;
      w_idx_n = '0;
    end
    if (r_state == S_RD) w_state_n = S_CALC;
    if (r_state == S_CALC && w_fire) w_state_n = S_SPK;
    if (r_state == S_DONE) w_state_n = S_IDLE;
    if (w_adv) begin
      w_state_n = w_last ? S_DONE : (r_state == S_CLR) ? S_CLR : S_RD;
      w_idx_n = w_last ? r_idx : r_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx <= '0;
      r_leak <= 1'b0;
      r_wr_en <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_spk_valid <= 1'b0;
      r_spk_idx <= '0;
    end else begin
      r_state <= w_state_n;
      r_idx <= w_idx_n;
      if (r_state == S_IDLE && start) r_leak <= leak;
      r_wr_en <= w_wr;
      if (w_wr) begin
        r_wr_addr <= r_idx[ADDR_W-1:0];
        r_wr_data <= (r_state == S_CLR) ? WIDTH'(RESET_VAL) : w_next_mem;
      end
      // The spike is raised alongside the neuron's write so a stalled SPK never re-writes it.
      if (r_state == S_CALC && w_fire) begin
        r_spk_valid <= 1'b1;
        r_spk_idx <= r_idx[ADDR_W-1:0];
      end else if (r_state == S_SPK && spk_ready) begin
        r_spk_valid <= 1'b0;
      end
    end
  end

  assign busy = r_state != S_IDLE;
  assign done = r_state == S_DONE;
  assign rd_en = r_state == S_RD;
  assign rd_addr = r_idx[ADDR_W-1:0];
  assign mem_wr_en = r_wr_en;
  assign mem_wr_addr = r_wr_addr;
  assign mem_wr_data = r_wr_data;
  assign spk_valid = r_spk_valid;
  assign spk_idx = r_spk_idx;
endmodule

// File: tb/tb_lif_layer_sched.sv
// tb_lif_layer_sched: table-driven update passes on a 4-neuron layer plus clear and reset sequences on 8/4-neuron layers.
module tb_lif_layer_sched;
  typedef struct {
    logic [3:0][31:0] m;
    logic [3:0][31:0] c;
    logic leak;
    int stall;
    logic [3:0][31:0] em;
    logic [3:0] mask;
    int done_at;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start4 = 1'b0, start8 = 1'b0, clear = 1'b0, leak = 1'b0, spk_ready = 1'b0;
  logic ld = 1'b0, mon_clr = 1'b0;
  int stall_cfg = 0, scnt = 0, cyc = 0;
  logic [3:0][31:0] ld_m4 = '0, ld_c4 = '0;
  logic [7:0][31:0] ld_m8 = '0;

  logic busy4, done4, rd_en4, mem_wr_en4, spk_valid4;
  logic [1:0] rd_addr4, mem_wr_addr4, spk_idx4;
  logic [31:0] mem_rd4 = '0, cur_rd4 = '0, mem_wr_data4;
  logic busy8, done8, rd_en8, mem_wr_en8, spk_valid8;
  logic [2:0] rd_addr8, mem_wr_addr8, spk_idx8;
  logic [31:0] mem_rd8 = '0, cur_rd8 = '0, mem_wr_data8;

  lif_layer_sched #(.N_NEURONS(4)) u_dut (
    .clk(clk), .rst(rst), .start(start4), .clear(clear), .leak(leak),
    .busy(busy4), .done(done4), .rd_en(rd_en4), .rd_addr(rd_addr4),
    .mem_rd_data(mem_rd4), .cur_rd_data(cur_rd4),
    .mem_wr_en(mem_wr_en4), .mem_wr_addr(mem_wr_addr4), .mem_wr_data(mem_wr_data4),
    .spk_valid(spk_valid4), .spk_idx(spk_idx4), .spk_ready(spk_ready)
  );

  lif_layer_sched #(.N_NEURONS(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .clear(clear), .leak(leak),
    .busy(busy8), .done(done8), .rd_en(rd_en8), .rd_addr(rd_addr8),
    .mem_rd_data(mem_rd8), .cur_rd_data(cur_rd8),
    .mem_wr_en(mem_wr_en8), .mem_wr_addr(mem_wr_addr8), .mem_wr_data(mem_wr_data8),
    .spk_valid(spk_valid8), .spk_idx(spk_idx8), .spk_ready(spk_ready)
  );

  logic [31:0] mem4 [4];
  logic [31:0] cur4 [4];
  logic [31:0] mem8 [8];
  int wcnt4 [4];
  int wcnt8 [8];
  int w0cyc8 = 0, w7cyc8 = 0, stab_bad = 0, coin_bad = 0, spk8_seen = 0;
  logic [1:0] spk_q [$];
  logic pv = 1'b0, pr = 1'b0;
  logic [1:0] pidx = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ld) begin
      for (int i = 0; i < 4; i++) begin
        mem4[i] <= ld_m4[i];
        cur4[i] <= ld_c4[i];
      end
      for (int i = 0; i < 8; i++) mem8[i] <= ld_m8[i];
    end else begin
      if (mem_wr_en4) mem4[mem_wr_addr4] <= mem_wr_data4;
      if (mem_wr_en8) mem8[mem_wr_addr8] <= mem_wr_data8;
    end
    if (rd_en4) begin
      mem_rd4 <= mem4[rd_addr4];
      cur_rd4 <= cur4[rd_addr4];
    end
    if (rd_en8) begin
      mem_rd8 <= mem8[rd_addr8];
      cur_rd8 <= 32'd0;
    end
    if (mon_clr) begin
      for (int i = 0; i < 4; i++) wcnt4[i] <= 0;
      for (int i = 0; i < 8; i++) wcnt8[i] <= 0;
      spk_q.delete();
      stab_bad <= 0;
      coin_bad <= 0;
      spk8_seen <= 0;
    end else begin
      if (mem_wr_en4) wcnt4[mem_wr_addr4] <= wcnt4[mem_wr_addr4] + 1;
      if (mem_wr_en8) begin
        wcnt8[mem_wr_addr8] <= wcnt8[mem_wr_addr8] + 1;
        if (mem_wr_addr8 == 3'd0) w0cyc8 <= cyc;
        if (mem_wr_addr8 == 3'd7) w7cyc8 <= cyc;
      end
      if (spk_valid4 && spk_ready) spk_q.push_back(spk_idx4);
      if (spk_valid4 && pv && !pr && spk_idx4 != pidx) stab_bad <= stab_bad + 1;
      if (spk_valid4 && !pv && !(mem_wr_en4 && mem_wr_addr4 == spk_idx4)) coin_bad <= coin_bad + 1;
      if (spk_valid8 || rd_en8) spk8_seen <= spk8_seen + 1;
    end
    pv <= spk_valid4;
    pr <= spk_ready;
    pidx <= spk_idx4;
  end

  // Downstream holds ready low for stall_cfg cycles of every offered spike.
  always @(negedge clk) begin
    if (spk_valid4) begin
      spk_ready <= (scnt >= stall_cfg);
      scnt <= scnt + 1;
    end else begin
      spk_ready <= (stall_cfg == 0);
      scnt <= 0;
    end
  end

  int checks = 0, errors = 0;
  vec_t vt [5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0][31:0] a4(input logic [31:0] x0, input logic [31:0] x1,
                                           input logic [31:0] x2, input logic [31:0] x3);
    logic [3:0][31:0] r;
    r[0] = x0;
    r[1] = x1;
    r[2] = x2;
    r[3] = x3;
    return r;
  endfunction

  task automatic run_vec(input vec_t v);
    int k, j;
    @(negedge clk);
    ld_m4 = v.m;
    ld_c4 = v.c;
    ld = 1'b1;
    mon_clr = 1'b1;
    stall_cfg = v.stall;
    @(negedge clk);
    ld = 1'b0;
    mon_clr = 1'b0;
    start4 = 1'b1;
    clear = 1'b0;
    leak = v.leak;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    leak = ~v.leak;
    k = 1;
    chk("busy_t1", 64'(busy4), 64'd1);
    chk("rd_t1", 64'({rd_en4, rd_addr4}), 64'({1'b1, 2'b00}));
    while (!done4 && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("done_cycle", 64'(k), 64'(v.done_at));
    @(posedge clk);
    #1;
    chk("idle_after_done", 64'({busy4, done4}), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("mem_value", 64'(mem4[i]), 64'(v.em[i]));
      chk("write_once", 64'(wcnt4[i]), 64'd1);
    end
    j = 0;
    for (int i = 0; i < 4; i++) begin
      if (v.mask[i]) begin
        chk("spike_order", (j < spk_q.size()) ? 64'(spk_q[j]) : 64'hdead, 64'(i));
        j++;
      end
    end
    chk("spike_count", 64'(spk_q.size()), 64'(j));
    chk("spike_stable", 64'(stab_bad), 64'd0);
    chk("spike_with_write", 64'(coin_bad), 64'd0);
    stall_cfg = 0;
  endtask

  initial begin
    int k, t0;
    vt[0] = '{a4(0, 1, 2, 3), a4(1, 1, 1, 1), 1'b0, 0, a4(1, 2, 3, 4), 4'b0000, 9};
    vt[1] = '{a4(10, 10, 30, 10), a4(0, 0, 5, 0), 1'b1, 0, a4(5, 5, 0, 5), 4'b0100, 10};
    vt[2] = '{a4(32'h7FFFFFF0, 32'h80000010, 0, -7), a4(32'h20, -32, 31, 0), 1'b0, 0,
              a4(0, -32, 31, -7), 4'b0001, 10};
    vt[3] = '{a4(-7, 64, 32, 3), a4(0, 0, 0, -1), 1'b1, 0, a4(-4, 0, 0, 1), 4'b0110, 11};
    vt[4] = '{a4(40, 50, 60, 70), a4(0, 0, 0, 0), 1'b0, 3, a4(0, 0, 0, 0), 4'b1111, 25};
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs4", 64'({busy4, done4, rd_en4, rd_addr4, mem_wr_en4, mem_wr_addr4, spk_valid4, spk_idx4}), 64'd0);
    chk("reset_data4", 64'(mem_wr_data4), 64'd0);
    chk("reset_outs8", 64'({busy8, done8, rd_en8, mem_wr_en8, spk_valid8, mem_wr_data8}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) run_vec(vt[i]);
    // Clear pass on the 8-neuron layer with a stray start mid-pass.
    @(negedge clk);
    for (int i = 0; i < 8; i++) ld_m8[i] = 32'(100 + i);
    ld = 1'b1;
    mon_clr = 1'b1;
    @(negedge clk);
    ld = 1'b0;
    mon_clr = 1'b0;
    start8 = 1'b1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    clear = 1'b0;
    k = 1;
    t0 = cyc;
    chk("clr_busy_t1", 64'(busy8), 64'd1);
    while (!done8 && k < 200) begin
      @(posedge clk);
      #1;
      k++;
      start8 = (k == 4);
    end
    start8 = 1'b0;
    chk("clr_done_cycle", 64'(k), 64'd9);
    @(posedge clk);
    #1;
    chk("clr_idle", 64'(busy8), 64'd0);
    for (int i = 0; i < 8; i++) begin
      chk("clr_mem", 64'(mem8[i]), 64'd0);
      chk("clr_write_once", 64'(wcnt8[i]), 64'd1);
    end
    chk("clr_first_write", 64'(w0cyc8), 64'(t0 + 1));
    chk("clr_last_write", 64'(w7cyc8), 64'(t0 + 8));
    chk("clr_no_reads", 64'(spk8_seen), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("clr_stray_start", 64'(busy8), 64'd0);
    // Reset while a spike is stalled, then a full fresh pass.
    @(negedge clk);
    ld_m4 = vt[4].m;
    ld_c4 = vt[4].c;
    ld = 1'b1;
    mon_clr = 1'b1;
    stall_cfg = 100;
    @(negedge clk);
    ld = 1'b0;
    mon_clr = 1'b0;
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    k = 0;
    while (!spk_valid4 && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("rst_reach_spk", 64'(spk_valid4), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_outs", 64'({busy4, done4, rd_en4, rd_addr4, mem_wr_en4, mem_wr_addr4, spk_valid4, spk_idx4}), 64'd0);
    chk("rst_mid_data", 64'(mem_wr_data4), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    stall_cfg = 0;
    @(posedge clk);
    #1;
    chk("rst_stays_idle", 64'({busy4, spk_valid4, mem_wr_en4}), 64'd0);
    run_vec(vt[0]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
